operand_tile_feeder: RTL

OPERAND_TILE_FEEDER -- requirements
Module: operand_tile_feeder

---
 rtl/operand_tile_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/operand_tile_feeder.sv
// operand_tile_feeder
// Collects an NxN A tile and an NxN B tile, one row per load beat. It then
// streams N beats to a systolic array. Beat k carries column k of A and row k
// of B.
// Optional build macro: OPERAND_TILE_FEEDER_PERF_EN adds two saturating
// performance counters, tiles_done and stall_cycles.
//
// state     | meaning
// ----------+----------------------------------------------------------
// LOAD_A    | accepting rows of A into buffer A, cnt = row index
// LOAD_B    | accepting rows of B into buffer B, cnt = row index
// STREAM    | presenting beat cnt to the array, advancing on input_ready
module operand_tile_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]   load_row,
  output logic                           a_input_valid,
  output logic                           b_input_valid,
  input  logic                           input_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]   a_data,
  output logic [N-1:0][DATA_WIDTH-1:0]   b_data,
  output logic                           last,
  output logic                           busy
`ifdef OPERAND_TILE_FEEDER_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]           tiles_done,
  output logic [CNT_WIDTH-1:0]           stall_cycles
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]                          r_state;
  logic [CW-1:0]                       r_cnt;
  logic [N-1:0][DATA_WIDTH-1:0]        r_buf_a [N];
  logic [N-1:0][DATA_WIDTH-1:0]        r_buf_b [N];

  logic w_in_stream;
  logic w_cnt_last;
  logic w_load_fire;
  logic w_beat_done;

  assign w_in_stream = (r_state == ST_STREAM);
  assign w_cnt_last  = (r_cnt == LAST_IDX);
  assign w_load_fire = load_valid && load_ready;
  assign w_beat_done = w_in_stream && input_ready;

  // Sequence control: state and the shared row/beat counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_LOAD_A;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_LOAD_A: begin
          if (w_load_fire) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_LOAD_B;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (w_load_fire) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_STREAM;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (input_ready) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_LOAD_A;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_LOAD_A;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Tile buffers: a row write per accepted load beat, cleared on reset so a
  // discarded partial tile never leaks into the next one
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else if (w_load_fire) begin
      if (r_state == ST_LOAD_A) begin
        r_buf_a[r_cnt] <= load_row;
      end else begin
        r_buf_b[r_cnt] <= load_row;
      end
    end
  end

  // Stream outputs: column cnt of A and row cnt of B, forced to zero off-stream
  always_comb begin
    a_data        = '0;
    b_data        = '0;
    last          = 1'b0;
    a_input_valid = 1'b0;
    b_input_valid = 1'b0;
    if (w_in_stream) begin
      a_input_valid = 1'b1;
      b_input_valid = 1'b1;
      last          = w_cnt_last;
      for (int i = 0; i < N; i++) begin
        a_data[i] = r_buf_a[i][r_cnt];
      end
      b_data = r_buf_b[r_cnt];
    end
  end

  // Handshake and status flags
  always_comb begin
    load_ready = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    busy       = (r_state != ST_LOAD_A) || (r_cnt != '0);
  end

`ifdef OPERAND_TILE_FEEDER_PERF_EN
  logic [CNT_WIDTH-1:0] r_tiles_done;
  logic [CNT_WIDTH-1:0] r_stall_cycles;

  // Saturating counters of completed tiles and back-pressured stream cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tiles_done   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_beat_done && w_cnt_last && (r_tiles_done != '1)) begin
        r_tiles_done <= r_tiles_done + CNT_WIDTH'(1);
      end
      if (w_in_stream && !input_ready && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

  assign tiles_done   = r_tiles_done;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
